stage2_feeder: RTL and testbench
================================

Name: stage2_feeder

Overview:
- Serializing driver for the second MLP layer.
- Accepts one S1_NUM-element activation vector from stage 1 over a valid/ready handshake and holds the S1_NUM x S2_NUM weight matrix in internal registers.
- Streams one activation per cycle on inp, with the matching weight row on weights[], and holds enable high for exactly S1_NUM consecutive cycles so the S2_NUM MAC lanes downstream accumulate one full dot product.

Parameters:
- S1_NUM, 8: activations per vector; stream length in cycles.
- S2_NUM, 8: number of downstream MAC lanes; weights per row.
- DATA_WIDTH, 8: signed Q4.4 element width for activations and weights.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation vector present on in_vec.
- in_ready  out  1  feeder can accept a vector.
- in_vec  in  S1_NUM x DATA_WIDTH (signed unpacked array)  stage-1 activations.
- w_wr_en  in  1  weight row write strobe.
- w_row  in  max(1,$clog2(S1_NUM))  row index k being written.
- w_data  in  S2_NUM x DATA_WIDTH (signed unpacked array)  weights W[k][0..S2_NUM-1].
- w_err  out  1  one-cycle pulse when a weight write is rejected.
- inp  out  DATA_WIDTH signed  current activation to the MAC lanes.
- weights  out  S2_NUM x DATA_WIDTH signed  current weight row to the MAC lanes.
- enable  out  1  MAC accumulate enable.
- vec_done  out  1  one-cycle pulse after the last element of a vector.

Behaviour:
- Reset (asynchronous, reset low):
  - state goes to IDLE; count = 0.
  - Vector register and weight matrix clear to 0.
  - inp = 0, weights = all 0, enable = 0, vec_done = 0, w_err = 0, in_ready = 0 while reset is held.
  - A reset during STREAM aborts the vector and drops enable in the same instant (asynchronous).
- State machine (registered outputs):
  - IDLE: in_ready = 1. A transfer occurs when in_valid & in_ready at an edge: capture in_vec into vec_q, count = 0, go to STREAM.
  - STREAM: in_ready = 0, enable = 1, inp = vec_q[count], weights = W[count][*]. count increments each cycle. When count == S1_NUM-1, the next state is DONE.
  - DONE: lasts one cycle. enable = 0, vec_done = 1, in_ready = 0. Next state is IDLE.
- Timing, for a handshake at edge T:
  - enable is high on cycles T+1 .. T+S1_NUM.
  - inp = vec[k] on cycle T+1+k.
  - vec_done is high on cycle T+S1_NUM+1.
  - in_ready is high again on cycle T+S1_NUM+2.
  - Minimum vector period is S1_NUM+2 cycles. The idle cycle between streams separates consecutive dot products at the MAC lanes.
- Outputs outside STREAM: inp and weights are driven 0 whenever enable = 0.
- Weight writes:
  - In IDLE or DONE: W[w_row] <= w_data at the edge.
  - In STREAM: the write is dropped, no weight changes, and w_err pulses high for the following cycle.
  - w_row >= S1_NUM: the write is dropped and w_err pulses.
  - Write and vector handshake at the same edge in IDLE: the write commits, and the first streamed row (T+1) already sees the new data if w_row = 0.
- in_valid while in_ready = 0 has no effect. The upstream side holds in_vec until the handshake.
- No arithmetic is performed; values pass bit-exact. Signedness is preserved.
- S1_NUM = 1: STREAM lasts exactly one cycle; the count width is forced to 1 bit.

Decomposition:
- Shared package mlp_pkg:
  - typedef q44_t (signed [DATA_WIDTH-1:0]).
  - Default S1_NUM / S2_NUM / DATA_WIDTH constants.
  - Feeder state enum {IDLE, STREAM, DONE}.
- One natural sub-module, weight_row_bank:
  - S1_NUM x S2_NUM register file with guarded row write, combinational row read by index, and asynchronous active-low clear.
  - The FSM, vector capture and output registers stay in stage2_feeder.

Test Plan:
- Reset value check:
  - Stimulus: hold reset low 3 cycles, then release.
  - Required: in_ready = 1 on the first cycle after release; enable = 0, inp = 0, weights all 0, vec_done = 0 throughout.
- Basic stream:
  - Stimulus: write row k with all lanes = 8'h10+k; present in_vec = {1,2,...,8} with in_valid.
  - Required: enable high 8 cycles; inp = 1..8 in order; weights = 8'h10..8'h17 per cycle; vec_done pulses on cycle T+9; in_ready returns on cycle T+10.
- Signed pass-through:
  - Stimulus: in_vec = {8'h80, 8'h7F, 8'hFF, 0, ...}.
  - Required: inp shows those bytes bit-exact; downstream MAC lanes with weights = 8'h10 (1.0) accumulate -128+127-1 = -2 in Q4.4.
- Write during STREAM:
  - Stimulus: w_wr_en asserted at stream cycle 3 with w_row = 5.
  - Required: w_err pulses one cycle; row 5 is unchanged in the current and next vector.
- Back-to-back vectors:
  - Stimulus: in_valid held high with two different vectors.
  - Required: second handshake occurs exactly S1_NUM+2 cycles after the first; exactly one enable-low cycle between the two streams.
- Reset mid-stream:
  - Stimulus: assert reset at stream cycle 4.
  - Required: enable drops immediately; all weights read 0 afterwards; the next vector streams from element 0.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath blocks.
//   q44_t           signed Q4.4 element (activations and weights)
//   *_DEF           default layer dimensions and element width
//   feeder_state_t  stage-2 feeder sequencing states
package mlp_pkg;

  localparam int S1_NUM_DEF     = 8;
  localparam int S2_NUM_DEF     = 8;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic signed [DATA_WIDTH_DEF-1:0] q44_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/weight_row_bank.sv
// S1_NUM x S2_NUM weight register file.
//   clk, rst_n        clock, asynchronous active-low clear of every entry
//   wr_en/wr_row/     row write; wr_row must already be range-checked
//   wr_data           by the caller
//   rd_row/rd_data    combinational read of one full row
module weight_row_bank #(
  parameter int S1_NUM     = 8,
  parameter int S2_NUM     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ROW_W-1:0]             wr_row,
  input  logic signed [DATA_WIDTH-1:0] wr_data [S2_NUM],
  input  logic [ROW_W-1:0]             rd_row,
  output logic signed [DATA_WIDTH-1:0] rd_data [S2_NUM]
);

  logic signed [DATA_WIDTH-1:0] rows_q [S1_NUM][S2_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < S1_NUM; r++) begin
        for (int l = 0; l < S2_NUM; l++) begin
          rows_q[r][l] <= '0;
        end
      end
    end else if (wr_en) begin
      rows_q[wr_row] <= wr_data;
    end
  end

  assign rd_data = rows_q[rd_row];

endmodule

// File: rtl/stage2_feeder.sv
// Serializing driver for the second MLP layer. Captures one activation
// vector, then streams one activation per cycle together with the matching
// weight row so the downstream MAC lanes accumulate a full dot product.
//   clk, reset        clock, asynchronous active-low reset
//   in_valid/in_ready/in_vec   vector handshake from stage 1
//   w_wr_en/w_row/w_data       weight row write; w_err flags rejected writes
//   inp, weights, enable       per-cycle MAC lane feed
//   vec_done          one-cycle pulse after the last element
//
// state  | meaning
// IDLE   | ready for a vector, weight writes accepted
// STREAM | feeding element count_q, enable high, weight writes rejected
// DONE   | one-cycle end-of-vector marker, weight writes accepted
module stage2_feeder
  import mlp_pkg::*;
#(
  parameter int S1_NUM     = S1_NUM_DEF,
  parameter int S2_NUM     = S2_NUM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic signed [DATA_WIDTH-1:0]                    in_vec [S1_NUM],
  input  logic                                            w_wr_en,
  input  logic [(S1_NUM > 1 ? $clog2(S1_NUM) : 1)-1:0]    w_row,
  input  logic signed [DATA_WIDTH-1:0]                    w_data [S2_NUM],
  output logic                                            w_err,
  output logic signed [DATA_WIDTH-1:0]                    inp,
  output logic signed [DATA_WIDTH-1:0]                    weights [S2_NUM],
  output logic                                            enable,
  output logic                                            vec_done
);

  localparam int ROW_W = (S1_NUM > 1) ? $clog2(S1_NUM) : 1;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(S1_NUM - 1);

  feeder_state_t                state_q, state_d;
  logic [ROW_W-1:0]             count_q;
  logic signed [DATA_WIDTH-1:0] vec_q [S1_NUM];
  logic signed [DATA_WIDTH-1:0] row_rd [S2_NUM];
  int                           row_idx;
  logic                         wr_ok;

  // Widened so the range check stays meaningful when S1_NUM is not a
  // power of two, without a constant-folded compare when it is.
  assign row_idx = int'(w_row);
  assign wr_ok   = w_wr_en && (state_q != STREAM) && (row_idx < S1_NUM);

  weight_row_bank #(
    .S1_NUM     (S1_NUM),
    .S2_NUM     (S2_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .ROW_W      (ROW_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_ok),
    .wr_row  (w_row),
    .wr_data (w_data),
    .rd_row  (count_q),
    .rd_data (row_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      w_err   <= 1'b0;
      for (int i = 0; i < S1_NUM; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      w_err   <= w_wr_en && !wr_ok;
      if (state_q == IDLE && in_valid) begin
        count_q <= '0;
        vec_q   <= in_vec;
      end else if (state_q == STREAM) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = STREAM;
      STREAM:  if (count_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so an asynchronous reset
  // drops enable and the lane feed in the same instant.
  always_comb begin
    in_ready = 1'b0;
    enable   = 1'b0;
    vec_done = 1'b0;
    inp      = '0;
    for (int l = 0; l < S2_NUM; l++) begin
      weights[l] = '0;
    end
    case (state_q)
      IDLE:   in_ready = reset;
      STREAM: begin
        enable  = 1'b1;
        inp     = vec_q[count_q];
        weights = row_rd;
      end
      DONE:    vec_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage2_feeder.sv
module tb_stage2_feeder;
  import mlp_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  q44_t       in_vec [8];
  logic       w_wr_en;
  logic [2:0] w_row;
  q44_t       w_data [8];
  logic       w_err;
  q44_t       inp;
  q44_t       weights [8];
  logic       enable;
  logic       vec_done;

  logic [63:0] wflat;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int l = 0; l < 8; l++) wflat[l*8 +: 8] = weights[l];
  end

  stage2_feeder #(.S1_NUM(8), .S2_NUM(8), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .w_wr_en  (w_wr_en),
    .w_row    (w_row),
    .w_data   (w_data),
    .w_err    (w_err),
    .inp      (inp),
    .weights  (weights),
    .enable   (enable),
    .vec_done (vec_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wdata(input logic [7:0] b);
    for (int l = 0; l < 8; l++) w_data[l] = b;
  endtask

  task automatic write_row(input int r, input logic [7:0] b);
    w_wr_en = 1'b1;
    w_row   = 3'(r);
    set_wdata(b);
    tick();
    w_wr_en = 1'b0;
    chk("idle_write_no_err", {63'd0, w_err}, 64'd0);
  endtask

  logic [7:0] vec_a [8];
  logic [7:0] vec_b [8];
  logic [7:0] rb;
  int         acc;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
    w_row    = 3'd0;
    set_wdata(8'h00);
    for (int k = 0; k < 8; k++) in_vec[k] = '0;

    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_enable", {63'd0, enable}, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_done", {63'd0, vec_done}, 64'd0);
      chk("rst_inp", {56'd0, inp}, 64'd0);
      chk("rst_weights", wflat, 64'd0);
    end
    reset = 1'b1;
    #1;
    chk("ready_after_release", {63'd0, in_ready}, 64'd1);
    chk("enable_after_release", {63'd0, enable}, 64'd0);

    // Basic stream: row k lanes = 0x10+k, vector 1..8
    for (int k = 0; k < 8; k++) write_row(k, 8'(8'h10 + k));
    for (int k = 0; k < 8; k++) in_vec[k] = 8'(k + 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rb = 8'(8'h10 + k);
      chk("basic_enable", {63'd0, enable}, 64'd1);
      chk("basic_inp", {56'd0, inp}, {56'd0, 8'(k + 1)});
      chk("basic_weights", wflat, {8{rb}});
      chk("basic_ready_low", {63'd0, in_ready}, 64'd0);
      chk("basic_done_low", {63'd0, vec_done}, 64'd0);
      tick();
    end
    chk("basic_done_pulse", {63'd0, vec_done}, 64'd1);
    chk("basic_enable_off", {63'd0, enable}, 64'd0);
    chk("basic_inp_zero", {56'd0, inp}, 64'd0);
    chk("basic_weights_zero", wflat, 64'd0);
    chk("basic_ready_in_done", {63'd0, in_ready}, 64'd0);
    tick();
    chk("basic_ready_back", {63'd0, in_ready}, 64'd1);
    chk("basic_done_cleared", {63'd0, vec_done}, 64'd0);

    // Signed pass-through with unity weights
    for (int k = 0; k < 8; k++) write_row(k, 8'h10);
    in_vec[0] = 8'h80; in_vec[1] = 8'h7F; in_vec[2] = 8'hFF;
    for (int k = 3; k < 8; k++) in_vec[k] = 8'h00;
    vec_a[0] = 8'h80; vec_a[1] = 8'h7F; vec_a[2] = 8'hFF;
    for (int k = 3; k < 8; k++) vec_a[k] = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      chk("signed_inp", {56'd0, inp}, {56'd0, vec_a[k]});
      acc += int'(inp) * int'(weights[0]);
      tick();
    end
    chk("signed_mac_q44", 64'(acc >>> 4), 64'(-2));
    tick();

    // Row 5 distinct, then a write attempt to row 5 mid-stream
    write_row(5, 8'h55);
    for (int k = 0; k < 8; k++) begin
      vec_a[k]  = 8'(8'h20 + k);
      vec_b[k]  = 8'(8'hC0 + 3 * k);
      in_vec[k] = vec_a[k];
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rb = (k == 5) ? 8'h55 : 8'h10;
      chk("wstream_inp", {56'd0, inp}, {56'd0, vec_a[k]});
      chk("wstream_weights", wflat, {8{rb}});
      chk("wstream_err", {63'd0, w_err}, {63'd0, (k == 4)});
      if (k == 3) begin
        w_wr_en = 1'b1;
        w_row   = 3'd5;
        set_wdata(8'hAA);
      end
      tick();
      w_wr_en = 1'b0;
    end
    chk("wstream_done", {63'd0, vec_done}, 64'd1);
    tick();

    // Back-to-back vectors with a same-edge write to row 0
    in_valid = 1'b1;
    w_wr_en  = 1'b1;
    w_row    = 3'd0;
    set_wdata(8'h33);
    chk("b2b_ready_first", {63'd0, in_ready}, 64'd1);
    tick();
    w_wr_en = 1'b0;
    for (int k = 0; k < 8; k++) in_vec[k] = vec_b[k];
    for (int k = 0; k < 8; k++) begin
      rb = (k == 0) ? 8'h33 : ((k == 5) ? 8'h55 : 8'h10);
      chk("b2b_a_enable", {63'd0, enable}, 64'd1);
      chk("b2b_a_inp", {56'd0, inp}, {56'd0, vec_a[k]});
      chk("b2b_a_weights", wflat, {8{rb}});
      tick();
    end
    chk("b2b_gap_done_enable", {63'd0, enable}, 64'd0);
    chk("b2b_gap_done_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("b2b_gap_idle_enable", {63'd0, enable}, 64'd0);
    chk("b2b_second_handshake", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rb = (k == 0) ? 8'h33 : ((k == 5) ? 8'h55 : 8'h10);
      chk("b2b_b_enable", {63'd0, enable}, 64'd1);
      chk("b2b_b_inp", {56'd0, inp}, {56'd0, vec_b[k]});
      chk("b2b_b_weights", wflat, {8{rb}});
      tick();
    end
    chk("b2b_b_done", {63'd0, vec_done}, 64'd1);
    tick();

    // Reset at stream cycle 4
    for (int k = 0; k < 8; k++) in_vec[k] = vec_a[k];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_pre_inp", {56'd0, inp}, {56'd0, vec_a[4]});
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_enable_drop", {63'd0, enable}, 64'd0);
    chk("midrst_inp_zero", {56'd0, inp}, 64'd0);
    chk("midrst_ready_low", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_ready_back", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 8; k++) in_vec[k] = vec_b[k];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("midrst_enable", {63'd0, enable}, 64'd1);
      chk("midrst_inp", {56'd0, inp}, {56'd0, vec_b[k]});
      chk("midrst_weights_cleared", wflat, 64'd0);
      tick();
    end
    chk("midrst_done", {63'd0, vec_done}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
